rc4_task_sequencer: RTL and testbench
=====================================

// Module: rc4_task_sequencer
// PURPOSE
//  Top-level phase controller for the RC4 core. On a start request it runs the three S-RAM tasks in order:
//  init (s[i]=i), shuffle (key schedule), decrypt. It owns the single-port S-RAM: only the active task's
//  address/data/wen reach the RAM. It also latches the secret key and guards each phase with a watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max cycles in any *_WAIT state before ERROR (>=2)
//  KEY_W           24    secret key width
// PORTS
//  clk             in   1      system clock, all state on rising edge
//  reset_n         in   1      asynchronous active-low reset
//  start           in   1      level; sampled in IDLE/DONE/ERROR to begin a run
//  abort           in   1      synchronous; return to IDLE from any state
//  secret_key_in   in   KEY_W  key, captured on accepted start
//  secret_key      out  KEY_W  latched key, held stable for the whole run
//  init_start      out  1      1-cycle pulse launching init task
//  init_finish     in   1      level from init task
//  shuffle_start   out  1      1-cycle pulse launching shuffle task
//  shuffle_finish  in   1      level from shuffle task
//  decrypt_start   out  1      1-cycle pulse launching decrypt task
//  decrypt_finish  in   1      level from decrypt task
//  {init,shuffle,decrypt}_address in 8 / _data in 8 / _wen in 1: per-task S-RAM requests (9 ports)
//  s_address       out  8      to S-RAM
//  s_data          out  8      to S-RAM
//  s_wen           out  1      to S-RAM
//  memory_sel      out  2      00 init, 01 shuffle, 10 decrypt, 11 parked
//  busy            out  1      high from accepted start until DONE/ERROR/IDLE
//  done            out  1      high in DONE
//  error           out  1      high in ERROR
// BEHAVIOUR
//  Reset: state IDLE, memory_sel=11, all *_start=0, busy=done=error=0, secret_key=0, timer=0, edge regs=0.
//  States: IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, DONE, ERROR.
//  IDLE/DONE/ERROR + start=1 -> INIT_GO next cycle; secret_key<=secret_key_in, done/error cleared.
//  *_GO: corresponding *_start=1 for exactly this cycle; memory_sel set to the task; ->*_WAIT; timer<=0.
//  memory_sel is registered and changes on entry to *_GO; stays until the next *_GO or DONE/ERROR/IDLE (->11).
//  *_WAIT: advance on RISING edge of that task's finish (registered prev value), not on level; a finish
//   left high from a prior run is ignored. INIT_WAIT->SHUF_GO, SHUF_WAIT->DEC_GO, DEC_WAIT->DONE.
//  Latency: finish edge sampled at cycle N -> next *_start pulse at N+1. Full run = 3 GO + task cycles + 1.
//  Watchdog: timer increments each WAIT cycle; at TIMEOUT_CYCLES-1 with no edge -> ERROR.
//   Edge and timeout in same cycle: edge wins.
//  RAM mux (combinational from memory_sel): selected task's address/data/wen drive s_*. For 11, s_wen=0,
//   s_address=0, s_data=0. Non-selected task wen never reaches RAM.
//  abort=1: -> IDLE next cycle from any state, memory_sel=11, no start pulse; abort beats start/finish/timeout.
//  start while busy is ignored. secret_key does not change mid-run.
//  Async reset mid-run: immediately IDLE, s_wen=0; sub-tasks are reset by their own reset.
// TESTING
//  1 Reset: assert reset_n=0 mid-SHUF_WAIT -> s_wen=0, memory_sel=11, busy=0 same cycle, no start pulses.
//  2 Normal run: key 24'h000249, tasks finish after 256/768/64 cycles
//    -> one pulse each, in order, sel 00->01->10->11, done=1.
//  3 Stale finish: init_finish held 1 before start -> sequencer stays INIT_WAIT until 0->1 edge.
//  4 Timeout: TIMEOUT_CYCLES=16, shuffle never finishes -> error=1 exactly 16 cycles after SHUF_WAIT entry.
//    Check s_wen=0.
//  5 Abort mid DEC_WAIT with decrypt_finish rising same cycle -> IDLE, done stays 0.
//  6 Isolation: drive decrypt_wen=1 during shuffle phase -> s_wen follows shuffle_wen only.
//    Change secret_key_in mid-run -> secret_key unchanged.

Source files
------------

// File: rtl/rc4_task_sequencer_if.sv
// rtl/rc4_task_sequencer_if.sv - task handshake, S-RAM request and status bundle for the RC4 phase controller
interface rc4_task_sequencer_if #(
  parameter int KEY_W = 24
);
  logic             start;
  logic             abort;
  logic [KEY_W-1:0] secret_key_in;
  logic [KEY_W-1:0] secret_key;

  logic             init_start;
  logic             init_finish;
  logic             shuffle_start;
  logic             shuffle_finish;
  logic             decrypt_start;
  logic             decrypt_finish;

  logic [7:0]       init_address;
  logic [7:0]       init_data;
  logic             init_wen;
  logic [7:0]       shuffle_address;
  logic [7:0]       shuffle_data;
  logic             shuffle_wen;
  logic [7:0]       decrypt_address;
  logic [7:0]       decrypt_data;
  logic             decrypt_wen;

  logic [7:0]       s_address;
  logic [7:0]       s_data;
  logic             s_wen;
  logic [1:0]       memory_sel;

  logic             busy;
  logic             done;
  logic             error;

  // Sequencer side
  modport master (
    input  start, abort, secret_key_in,
    input  init_finish, shuffle_finish, decrypt_finish,
    input  init_address, init_data, init_wen,
    input  shuffle_address, shuffle_data, shuffle_wen,
    input  decrypt_address, decrypt_data, decrypt_wen,
    output secret_key, init_start, shuffle_start, decrypt_start,
    output s_address, s_data, s_wen, memory_sel,
    output busy, done, error
  );

  // Tasks / host side
  modport slave (
    output start, abort, secret_key_in,
    output init_finish, shuffle_finish, decrypt_finish,
    output init_address, init_data, init_wen,
    output shuffle_address, shuffle_data, shuffle_wen,
    output decrypt_address, decrypt_data, decrypt_wen,
    input  secret_key, init_start, shuffle_start, decrypt_start,
    input  s_address, s_data, s_wen, memory_sel,
    input  busy, done, error
  );
endinterface

// File: rtl/rc4_task_sequencer.sv
// rtl/rc4_task_sequencer.sv - RC4 phase controller: init/shuffle/decrypt sequencing, S-RAM ownership, watchdog
module rc4_task_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int KEY_W          = 24
) (
  input logic                   clk,
  input logic                   reset_n,
  rc4_task_sequencer_if.master  bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SEL_INIT    = 2'b00;
  localparam logic [1:0] SEL_SHUFFLE = 2'b01;
  localparam logic [1:0] SEL_DECRYPT = 2'b10;
  localparam logic [1:0] SEL_PARKED  = 2'b11;

  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, DONE, ERROR
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [KEY_W-1:0] key_q;
  logic [1:0]       sel_q;
  logic             init_start_q, shuffle_start_q, decrypt_start_q;
  logic             busy_q, done_q, error_q;
  logic             init_prev, shuffle_prev, decrypt_prev;
  logic             init_rise, shuffle_rise, decrypt_rise;
  logic             timeout;

  // Finish lines are levels; only a fresh 0->1 transition counts as completion.
  assign init_rise    = bus.init_finish    & ~init_prev;
  assign shuffle_rise = bus.shuffle_finish & ~shuffle_prev;
  assign decrypt_rise = bus.decrypt_finish & ~decrypt_prev;
  assign timeout      = (timer == TIMER_LAST);

  assign bus.secret_key    = key_q;
  assign bus.memory_sel    = sel_q;
  assign bus.init_start    = init_start_q;
  assign bus.shuffle_start = shuffle_start_q;
  assign bus.decrypt_start = decrypt_start_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;

  // Phase FSM: start pulses, RAM owner select and status are registered on entry to each state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      timer           <= '0;
      key_q           <= '0;
      sel_q           <= SEL_PARKED;
      init_start_q    <= 1'b0;
      shuffle_start_q <= 1'b0;
      decrypt_start_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      init_prev       <= 1'b0;
      shuffle_prev    <= 1'b0;
      decrypt_prev    <= 1'b0;
    end else begin
      init_prev       <= bus.init_finish;
      shuffle_prev    <= bus.shuffle_finish;
      decrypt_prev    <= bus.decrypt_finish;
      init_start_q    <= 1'b0;
      shuffle_start_q <= 1'b0;
      decrypt_start_q <= 1'b0;
      if (bus.abort) begin
        state   <= IDLE;
        sel_q   <= SEL_PARKED;
        timer   <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (bus.start) begin
              state        <= INIT_GO;
              init_start_q <= 1'b1;
              sel_q        <= SEL_INIT;
              key_q        <= bus.secret_key_in;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              error_q      <= 1'b0;
            end
          end
          INIT_GO: begin
            state <= INIT_WAIT;
            timer <= '0;
          end
          SHUF_GO: begin
            state <= SHUF_WAIT;
            timer <= '0;
          end
          DEC_GO: begin
            state <= DEC_WAIT;
            timer <= '0;
          end
          INIT_WAIT: begin
            if (init_rise) begin
              state           <= SHUF_GO;
              shuffle_start_q <= 1'b1;
              sel_q           <= SEL_SHUFFLE;
            end else if (timeout) begin
              state   <= ERROR;
              sel_q   <= SEL_PARKED;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          SHUF_WAIT: begin
            if (shuffle_rise) begin
              state           <= DEC_GO;
              decrypt_start_q <= 1'b1;
              sel_q           <= SEL_DECRYPT;
            end else if (timeout) begin
              state   <= ERROR;
              sel_q   <= SEL_PARKED;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          DEC_WAIT: begin
            if (decrypt_rise) begin
              state  <= DONE;
              sel_q  <= SEL_PARKED;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else if (timeout) begin
              state   <= ERROR;
              sel_q   <= SEL_PARKED;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            sel_q <= SEL_PARKED;
          end
        endcase
      end
    end
  end

  // S-RAM mux: only the selected task reaches the RAM; parked drives a harmless read of address 0.
  always_comb begin
    bus.s_address = 8'h00;
    bus.s_data    = 8'h00;
    bus.s_wen     = 1'b0;
    case (sel_q)
      SEL_INIT: begin
        bus.s_address = bus.init_address;
        bus.s_data    = bus.init_data;
        bus.s_wen     = bus.init_wen;
      end
      SEL_SHUFFLE: begin
        bus.s_address = bus.shuffle_address;
        bus.s_data    = bus.shuffle_data;
        bus.s_wen     = bus.shuffle_wen;
      end
      SEL_DECRYPT: begin
        bus.s_address = bus.decrypt_address;
        bus.s_data    = bus.decrypt_data;
        bus.s_wen     = bus.decrypt_wen;
      end
      default: begin
        bus.s_wen = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_task_sequencer.sv
// tb/tb_rc4_task_sequencer.sv - directed self-checking bench for rc4_task_sequencer
module tb_rc4_task_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;
  int   n_init = 0, n_shuf = 0, n_dec = 0;
  int   s_init, s_shuf, s_dec;

  always #5 clk = ~clk;

  rc4_task_sequencer_if #(.KEY_W(24)) a ();
  rc4_task_sequencer_if #(.KEY_W(24)) b ();

  rc4_task_sequencer #(.TIMEOUT_CYCLES(4096), .KEY_W(24)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a.master)
  );
  rc4_task_sequencer #(.TIMEOUT_CYCLES(16), .KEY_W(24)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b.master)
  );

  // Count start pulses (in cycles) seen on dut_a
  always @(negedge clk) begin
    if (a.init_start)    n_init = n_init + 1;
    if (a.shuffle_start) n_shuf = n_shuf + 1;
    if (a.decrypt_start) n_dec  = n_dec + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec = nvec + 1;
    assert (obs === exp) else begin
      nerr = nerr + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a.start = 0; a.abort = 0; a.secret_key_in = '0;
    a.init_finish = 0; a.shuffle_finish = 0; a.decrypt_finish = 0;
    a.init_address = 0; a.init_data = 0; a.init_wen = 0;
    a.shuffle_address = 0; a.shuffle_data = 0; a.shuffle_wen = 0;
    a.decrypt_address = 0; a.decrypt_data = 0; a.decrypt_wen = 0;
    b.start = 0; b.abort = 0; b.secret_key_in = '0;
    b.init_finish = 0; b.shuffle_finish = 0; b.decrypt_finish = 0;
    b.init_address = 0; b.init_data = 0; b.init_wen = 0;
    b.shuffle_address = 0; b.shuffle_data = 0; b.shuffle_wen = 0;
    b.decrypt_address = 0; b.decrypt_data = 0; b.decrypt_wen = 0;
    step(3);

    // Reset state
    chk("rst_sel",    32'(a.memory_sel), 32'd3);
    chk("rst_busy",   32'(a.busy), 32'd0);
    chk("rst_done",   32'(a.done), 32'd0);
    chk("rst_error",  32'(a.error), 32'd0);
    chk("rst_key",    32'(a.secret_key), 32'd0);
    chk("rst_swen",   32'(a.s_wen), 32'd0);
    chk("rst_starts", 32'({a.init_start, a.shuffle_start, a.decrypt_start}), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Normal run: key 000249, tasks 256/768/64 cycles
    s_init = n_init; s_shuf = n_shuf; s_dec = n_dec;
    a.secret_key_in = 24'h000249; a.start = 1;
    a.init_wen = 1; a.init_address = 8'h07; a.init_data = 8'h07;
    step(1);
    a.start = 0;
    chk("go_init_start", 32'(a.init_start), 32'd1);
    chk("go_init_sel",   32'(a.memory_sel), 32'd0);
    chk("go_busy",       32'(a.busy), 32'd1);
    chk("go_key",        32'(a.secret_key), 32'h000249);
    chk("init_mux",      32'({a.s_wen, a.s_address, a.s_data}), 32'h10707);
    step(1);
    chk("init_pulse_1cyc", 32'(a.init_start), 32'd0);
    step(254);
    a.init_finish = 1; a.init_wen = 0;
    step(1);
    chk("shuf_start", 32'(a.shuffle_start), 32'd1);
    chk("shuf_sel",   32'(a.memory_sel), 32'd1);

    // Isolation, key hold, start while busy
    a.shuffle_address = 8'h12; a.shuffle_data = 8'h34; a.shuffle_wen = 0;
    a.decrypt_address = 8'h55; a.decrypt_data = 8'h66; a.decrypt_wen = 1;
    a.secret_key_in = 24'hffffff; a.start = 1;
    step(1);
    a.start = 0;
    chk("iso_mux0",      32'({a.s_wen, a.s_address, a.s_data}), 32'h01234);
    chk("key_hold",      32'(a.secret_key), 32'h000249);
    chk("busy_start_ign", 32'({a.init_start, a.memory_sel}), 32'd1);
    a.shuffle_wen = 1;
    step(1);
    chk("iso_mux1",      32'({a.s_wen, a.s_address, a.s_data}), 32'h11234);
    a.shuffle_wen = 0;
    step(764);
    a.shuffle_finish = 1;
    step(1);
    chk("dec_start", 32'(a.decrypt_start), 32'd1);
    chk("dec_sel",   32'(a.memory_sel), 32'd2);
    chk("dec_mux",   32'({a.s_wen, a.s_address, a.s_data}), 32'h15566);
    step(63);
    a.decrypt_finish = 1;
    step(1);
    chk("done_flag",  32'({a.done, a.busy, a.error}), 32'b100);
    chk("done_sel",   32'(a.memory_sel), 32'd3);
    chk("done_swen",  32'(a.s_wen), 32'd0);
    chk("done_key",   32'(a.secret_key), 32'h000249);
    chk("pulse_count", 32'({8'(n_init - s_init), 8'(n_shuf - s_shuf), 8'(n_dec - s_dec)}), 32'h010101);

    // Stale finish: init_finish already high before start
    a.decrypt_wen = 0;
    s_shuf = n_shuf;
    a.secret_key_in = 24'h0abcde; a.start = 1;
    step(1);
    a.start = 0;
    chk("stale_go",   32'({a.init_start, a.done}), 32'b10);
    chk("stale_key",  32'(a.secret_key), 32'h0abcde);
    step(20);
    chk("stale_hold", 32'({a.memory_sel, a.busy}), 32'b001);
    chk("stale_noshuf", 32'(n_shuf - s_shuf), 32'd0);
    a.init_finish = 0;
    step(1);
    chk("stale_low",  32'(a.memory_sel), 32'd0);
    a.init_finish = 1;
    step(1);
    chk("stale_edge", 32'(a.shuffle_start), 32'd1);

    // Abort in DEC_WAIT on the same cycle decrypt_finish rises
    a.shuffle_finish = 0;
    step(3);
    a.shuffle_finish = 1;
    step(1);
    chk("abort_dec_go", 32'(a.decrypt_start), 32'd1);
    a.decrypt_finish = 0;
    step(5);
    a.decrypt_finish = 1; a.abort = 1;
    step(1);
    a.abort = 0;
    chk("abort_state", 32'({a.done, a.busy, a.error, a.decrypt_start}), 32'd0);
    chk("abort_sel",   32'(a.memory_sel), 32'd3);
    step(2);
    chk("abort_stay",  32'({a.done, a.memory_sel}), 32'b011);

    // Async reset mid SHUF_WAIT
    a.init_finish = 0; a.shuffle_finish = 0; a.decrypt_finish = 0;
    a.start = 1;
    step(1);
    a.start = 0;
    step(3);
    a.init_finish = 1; a.shuffle_wen = 1;
    step(3);
    chk("pre_rst_mux", 32'({a.s_wen, a.memory_sel, a.busy}), 32'b1011);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_swen",  32'(a.s_wen), 32'd0);
    chk("rst_mid_state", 32'({a.memory_sel, a.busy}), 32'b110);
    chk("rst_mid_pulse", 32'({a.init_start, a.shuffle_start, a.decrypt_start}), 32'd0);
    step(1);
    reset_n = 1'b1;
    a.shuffle_wen = 0; a.init_finish = 0;
    step(2);
    chk("rst_after", 32'({a.memory_sel, a.busy, a.done}), 32'b1100);

    // Watchdog on dut_b (TIMEOUT_CYCLES=16)
    b.start = 1;
    step(1);
    b.start = 0;
    chk("b_init_go", 32'(b.init_start), 32'd1);
    step(2);
    b.init_finish = 1;
    step(1);
    chk("b_shuf_go", 32'(b.shuffle_start), 32'd1);
    b.shuffle_wen = 1; b.shuffle_address = 8'h9a;
    step(1);
    step(15);
    chk("b_no_err_15", 32'({b.error, b.busy, b.memory_sel}), 32'b0101);
    step(1);
    chk("b_err_16",    32'({b.error, b.busy, b.memory_sel}), 32'b1011);
    chk("b_err_swen",  32'(b.s_wen), 32'd0);

    // Edge and timeout in the same cycle: edge wins
    b.init_finish = 0; b.start = 1;
    step(1);
    b.start = 0;
    chk("b_restart", 32'({b.error, b.init_start}), 32'b01);
    step(1);
    step(15);
    b.init_finish = 1;
    step(1);
    chk("b_edge_wins", 32'({b.error, b.shuffle_start, b.memory_sel}), 32'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
